aes128_enc_ctrl: RTL
====================

# aes128_enc_ctrl

Iterative AES-128 encryption controller that sequences the existing combinational round-stage modules (SubBytes, ShiftRows, MixColumns) over one round per clock. It owns the 128-bit state register, the on-the-fly key schedule and the round counter, and presents a valid/ready handshake on both the plaintext input and the ciphertext output. It sits between the host-side block interface and the ciphertext sink. Its datapath is time-shared across rounds 1–10.

## Interface
Parameters:
- none. Block size and key size are fixed at 128 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key valid.
- in_ready  out  1  block can accept a new plaintext/key.
- in_data  in  128  plaintext. Bits 127:120 are byte 0. Column-major: bits 127:96 are column 0.
- in_key  in  128  cipher key. Same byte order as in_data.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- out_data  out  128  ciphertext. Same byte order as in_data.
- in_key_keep  in  1  present only with AES128_KEY_KEEP_EN (see Configuration).

## Operation
- FSM states:
  - IDLE (reset state)
  - RUN
  - DONE
- IDLE:
  - in_ready = 1.
  - When in_valid is high: state_reg <= in_data ^ in_key, key_reg <= in_key, rcon <= 8'h01, rnd <= 1, go to RUN.
- RUN, per cycle:
  - round_key = expand(key_reg, rcon). expand is the standard AES-128 next-round-key function: RotWord, SubWord, XOR with {rcon,24'h0}, then the chained XOR of w0..w3.
  - Round function: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ round_key.
  - MixColumns is bypassed when rnd == 10.
  - key_reg <= round_key.
  - rcon <= xtime(rcon): shift left by 1, XOR 8'h1b if bit 7 was set. So 8'h80 goes to 8'h1b.
  - rnd <= rnd + 1. rnd is a 4-bit counter.
  - When rnd == 10: go to DONE instead of incrementing.
- DONE:
  - out_valid = 1 and out_data = state_reg.
  - out_data is held stable until out_ready is sampled high. Then go to IDLE.
- in_ready is high only in IDLE. in_data and in_key are ignored outside IDLE.
- out_valid is high only in DONE. out_data is don't-care outside DONE but is driven from state_reg.
- in_valid is ignored while in RUN or DONE. It does not queue.

## Timing
- Reset values:
  - FSM = IDLE, in_ready = 1, out_valid = 0.
  - out_data (state_reg) = 128'h0, key_reg = 0, rcon = 8'h01, rnd = 0.
- Latency:
  - The accept edge is E0, the first edge at which in_valid && in_ready.
  - Rounds execute on edges E1..E10.
  - out_valid is high from E10 onward, i.e. 10 cycles after the accept edge.
- Hand-off:
  - The DONE→IDLE edge is the first edge with out_ready high while in DONE.
  - in_ready rises the cycle after that edge.
  - Minimum block period is 12 cycles (with out_ready tied high).
- out_ready high while in IDLE or RUN has no effect.
- Reset asserted in any state takes effect at the next edge and overrides every other input. It aborts an in-flight block: no out_valid is produced and no state is retained.

## Configuration
- AES128_KEY_KEEP_EN defined:
  - Adds port in_key_keep and a 128-bit key_base register.
  - On accept with in_key_keep = 0: key_base <= in_key and the block uses in_key.
  - On accept with in_key_keep = 1: the block uses key_base and ignores in_key. key_base is unchanged.
  - key_base resets to 0.
- AES128_KEY_KEEP_EN undefined:
  - No in_key_keep port and no key_base register.
  - in_key is used on every accept.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → out_data 3925841d02dc09fbdc118597196a0b32. out_valid must rise exactly 10 cycles after the accept edge.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid rises. out_data must stay stable and in_ready must stay 0.
  - Toggle in_valid with different data during RUN and DONE. It must be ignored.
  - Release out_ready. in_ready must rise the following cycle.
- Back-to-back: App. B then App. C.1 with out_ready and in_valid held high → both ciphertexts correct, 12-cycle spacing between out_valid rises.
- Reset mid-operation:
  - Assert rst at round 5 for 1 cycle. The next cycle must show out_valid = 0, in_ready = 1, out_data = 0.
  - A subsequent App. C.1 block must produce the correct ciphertext.
- With AES128_KEY_KEEP_EN: load the App. B key, then send pt 3243f6a8885a308d313198a2e0370734 with in_key_keep = 1 and in_key = 0 → 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes128_enc_ctrl.sv
// aes128_enc_ctrl: iterative AES-128 encryptor, one round per clock.
// The block takes plaintext and key through a valid/ready handshake, runs ten
// rounds over a shared datapath, and holds the ciphertext until the sink takes it.
// Optional feature macro: AES128_KEY_KEEP_EN. When defined, it adds in_key_keep and
// a stored base key that later blocks can reuse.

// S-box byte lane. The multiplicative inverse is computed as x^254 in GF(2^8),
// followed by the affine transform, so no 256-entry table is needed.
module aes128_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

    // Addition chain to x^254. An input of 0 maps to 0, as the S-box requires.
    assign w_x2   = gmul(i_byte, i_byte);
    assign w_x3   = gmul(w_x2, i_byte);
    assign w_x6   = gmul(w_x3, w_x3);
    assign w_x12  = gmul(w_x6, w_x6);
    assign w_x15  = gmul(w_x12, w_x3);
    assign w_x30  = gmul(w_x15, w_x15);
    assign w_x60  = gmul(w_x30, w_x30);
    assign w_x120 = gmul(w_x60, w_x60);
    assign w_x240 = gmul(w_x120, w_x120);
    assign w_x252 = gmul(w_x240, w_x12);
    assign w_inv  = gmul(w_x252, w_x2);

    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;
endmodule

// MixColumns for a single column. Byte a0 (row 0) is in bits 31:24.
module aes128_mixcol (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col[31:24] = xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_col[23:16] = w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3;
    assign o_col[15:8]  = w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3;
    assign o_col[7:0]   = xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3);
endmodule

module aes128_enc_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef AES128_KEY_KEEP_EN
    ,
    input  logic         in_key_keep
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t       r_fsm, w_fsm_nxt;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [7:0]   r_rcon;
    logic [3:0]   r_rnd;

    logic         w_accept;
    logic         w_last;
    logic [127:0] w_key_sel;

    // Round datapath wires. Byte b of a 128-bit word sits at bits [127-8b -: 8].
    logic [15:0][7:0] w_sub;
    logic [15:0][7:0] w_shr;
    logic [127:0]     w_shr_flat;
    logic [127:0]     w_mix_flat;
    logic [127:0]     w_round_out;

    // Key schedule wires
    logic [31:0]      w_w0, w_w1, w_w2, w_w3, w_rot, w_temp;
    logic [3:0][7:0]  w_subw;
    logic [31:0]      w_n0, w_n1, w_n2, w_n3;
    logic [127:0]     w_rkey;
    logic [7:0]       w_rcon_nxt;

    assign w_accept = (r_fsm == S_IDLE) && in_valid;
    assign w_last   = (r_rnd == 4'd10);

`ifdef AES128_KEY_KEEP_EN
    logic [127:0] r_key_base;

    assign w_key_sel = in_key_keep ? r_key_base : in_key;

    // Base key register. It is replaced only when a block is accepted with keep low.
    always_ff @(posedge clk) begin
        if (rst)
            r_key_base <= 128'h0;
        else if (w_accept && !in_key_keep)
            r_key_base <= in_key;
    end
`else
    assign w_key_sel = in_key;
`endif

    // SubBytes: one S-box lane per state byte
    genvar gb;
    generate
        for (gb = 0; gb < 16; gb++) begin : g_sub
            aes128_sbox u_sbox (
                .i_byte (r_state[127-8*gb -: 8]),
                .o_byte (w_sub[gb])
            );
        end
    endgenerate

    // ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
    // MixColumns runs per column on the shifted bytes.
    genvar gr, gc;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign w_shr[gr+4*gc] = w_sub[gr+4*((gc+gr)%4)];
            end
            assign w_shr_flat[127-32*gc -: 32] = {w_shr[4*gc], w_shr[4*gc+1],
                                                  w_shr[4*gc+2], w_shr[4*gc+3]};
            aes128_mixcol u_mix (
                .i_col (w_shr_flat[127-32*gc -: 32]),
                .o_col (w_mix_flat[127-32*gc -: 32])
            );
        end
    endgenerate

    // The final round skips MixColumns.
    assign w_round_out = w_last ? w_shr_flat : w_mix_flat;

    // On-the-fly next round key: SubWord(RotWord(w3)) ^ rcon, then the chained XOR
    assign w_w0  = r_key[127:96];
    assign w_w1  = r_key[95:64];
    assign w_w2  = r_key[63:32];
    assign w_w3  = r_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    genvar gk;
    generate
        for (gk = 0; gk < 4; gk++) begin : g_subw
            aes128_sbox u_sbox (
                .i_byte (w_rot[31-8*gk -: 8]),
                .o_byte (w_subw[3-gk])
            );
        end
    endgenerate

    assign w_temp     = w_subw ^ {r_rcon, 24'h0};
    assign w_n0       = w_w0 ^ w_temp;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_rkey     = {w_n0, w_n1, w_n2, w_n3};
    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            r_fsm <= S_IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_fsm_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // State, key, rcon and round counter: loaded on accept, stepped once per round
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= 128'h0;
            r_key   <= 128'h0;
            r_rcon  <= 8'h01;
            r_rnd   <= 4'd0;
        end else if (w_accept) begin
            r_state <= in_data ^ w_key_sel;
            r_key   <= w_key_sel;
            r_rcon  <= 8'h01;
            r_rnd   <= 4'd1;
        end else if (r_fsm == S_RUN) begin
            r_state <= w_round_out ^ w_rkey;
            r_key   <= w_rkey;
            r_rcon  <= w_rcon_nxt;
            if (!w_last) r_rnd <= r_rnd + 4'd1;
        end
    end

    assign out_data = r_state;
endmodule
